// File: rtl/ex_cnt_mod_pkg.sv
// Shared encodings for the ex_cnt_mod modulo counter.
package ex_cnt_mod_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } cnt_state_t;

   localparam logic MODE_WRAP    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;
   localparam logic DIR_UP       = 1'b1;

endpackage : ex_cnt_mod_pkg

// File: rtl/ex_cnt_mod_nxt.sv
// Next-value logic for ex_cnt_mod: step, wrap, terminal detect and start origin.
module ex_cnt_mod_nxt
   import ex_cnt_mod_pkg::*;
#(
   parameter int WIDTH   = 10,
   parameter int CNT_MAX = 999
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic             dir,
   output logic [WIDTH-1:0] nxt,
   output logic [WIDTH-1:0] origin,
   output logic             at_terminal,
   output logic             nxt_at_terminal
);

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(CNT_MAX);

   logic [WIDTH-1:0] term;

   // Terminal and origin follow the direction currently requested.
   always_comb begin
      term   = (dir == DIR_UP) ? MAX_W : '0;
      origin = (dir == DIR_UP) ? '0 : MAX_W;
   end

   // One step in the requested direction; wraps are explicit. The up-count
   // guard uses >= so an out-of-range value can never run through overflow.
   always_comb begin
      nxt         = cnt;
      at_terminal = (cnt == term);
      if (dir == DIR_UP) begin
         if (cnt >= MAX_W) nxt = '0;
         else              nxt = cnt + 1'b1;
      end else begin
         if (cnt == '0)    nxt = MAX_W;
         else              nxt = cnt - 1'b1;
      end
      nxt_at_terminal = (nxt == term);
   end

endmodule : ex_cnt_mod_nxt

// File: rtl/ex_cnt_mod.sv
// Parametrised modulo counter with enable, clear, load, up/down, wrap or
// one-shot run control and a registered terminal-count pulse.
//
//  state   | meaning
//  --------+------------------------------------------------
//  ST_IDLE | stopped after reset or clear, cnt holds
//  ST_RUN  | counting one step per enabled sclk
//  ST_DONE | one-shot reached terminal, cnt holds until start
module ex_cnt_mod
   import ex_cnt_mod_pkg::*;
#(
   parameter int WIDTH   = 10,
   parameter int CNT_MAX = 999
) (
   input  logic             sclk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             start,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   input  logic             mode,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
      $error("ex_cnt_mod: WIDTH must be in 1..31");
   end
   if (CNT_MAX < 1 || CNT_MAX > (2**WIDTH) - 1) begin : g_bad_max
      $error("ex_cnt_mod: CNT_MAX must be in 1..2**WIDTH-1");
   end

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(CNT_MAX);

   cnt_state_t       state;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] origin;
   logic [WIDTH-1:0] load_clamped;
   logic             at_terminal;
   logic             nxt_at_terminal;
   logic             start_ok;

   ex_cnt_mod_nxt #(
      .WIDTH   (WIDTH),
      .CNT_MAX (CNT_MAX)
   ) u_nxt (
      .cnt             (cnt),
      .dir             (dir),
      .nxt             (nxt),
      .origin          (origin),
      .at_terminal     (at_terminal),
      .nxt_at_terminal (nxt_at_terminal)
   );

   // Loads saturate at CNT_MAX; start is only honoured outside RUN.
   always_comb begin
      load_clamped = (load_val > MAX_W) ? MAX_W : load_val;
      start_ok     = start && (state != ST_RUN);
   end

   // Run FSM, priority mux (clr > load > start > step) and output registers.
   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         tc    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else if (clr) begin
         state <= ST_IDLE;
         cnt   <= '0;
         tc    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else if (load) begin
         cnt <= load_clamped;
         tc  <= 1'b0;
         if (start_ok) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
         end
      end else if (start_ok) begin
         state <= ST_RUN;
         cnt   <= origin;
         tc    <= 1'b0;
         busy  <= 1'b1;
         done  <= 1'b0;
      end else if (state == ST_RUN && en) begin
         if (at_terminal && mode == MODE_ONESHOT) begin
            // Sitting on terminal without having stepped there (load or dir
            // flip): finish the one-shot without a further step or pulse.
            state <= ST_DONE;
            tc    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
         end else begin
            cnt <= nxt;
            tc  <= nxt_at_terminal;
            if (nxt_at_terminal && mode == MODE_ONESHOT) begin
               state <= ST_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end
      end else begin
         tc <= 1'b0;
      end
   end

endmodule : ex_cnt_mod

// File: tb/tb_ex_cnt_mod.sv
// Directed bench for ex_cnt_mod with WIDTH=4, CNT_MAX=9.
module tb_ex_cnt_mod;

   localparam int W  = 4;
   localparam int MX = 9;

   logic         sclk;
   logic         rst_n;
   logic         en, clr, start, load, dir, mode;
   logic [W-1:0] load_val;
   logic [W-1:0] cnt;
   logic         tc, busy, done;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic         en;
      logic         clr;
      logic         start;
      logic         load;
      logic [W-1:0] lv;
      logic         dir;
      logic         mode;
      logic [W-1:0] e_cnt;
      logic         e_tc;
      logic         e_busy;
      logic         e_done;
   } vec_t;

   vec_t vecs[$];

   ex_cnt_mod #(.WIDTH(W), .CNT_MAX(MX)) dut (
      .sclk     (sclk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (clr),
      .start    (start),
      .load     (load),
      .load_val (load_val),
      .dir      (dir),
      .mode     (mode),
      .cnt      (cnt),
      .tc       (tc),
      .busy     (busy),
      .done     (done)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   function automatic vec_t mk(input logic e, input logic c, input logic s,
                               input logic l, input int lv, input logic d,
                               input logic m, input int ec, input logic et,
                               input logic eb, input logic ed);
      vec_t v;
      v.en = e; v.clr = c; v.start = s; v.load = l; v.lv = W'(lv);
      v.dir = d; v.mode = m; v.e_cnt = W'(ec); v.e_tc = et;
      v.e_busy = eb; v.e_done = ed;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input int ec, input int et,
                          input int eb, input int ed);
      chk({name, " cnt"},  int'(cnt),  ec);
      chk({name, " tc"},   int'(tc),   et);
      chk({name, " busy"}, int'(busy), eb);
      chk({name, " done"}, int'(done), ed);
   endtask

   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   task automatic idle_in();
      en = 0; clr = 0; start = 0; load = 0; load_val = '0; dir = 1; mode = 0;
   endtask

   task automatic do_reset();
      idle_in();
      rst_n = 0;
      step();
      step();
      rst_n = 1;
   endtask

   initial begin
      int tc_cnt;
      rst_n = 0;
      idle_in();

      // ---------------- test 1: reset mid-count ----------------
      do_reset();
      chk_all("reset", 0, 0, 0, 0);
      start = 1; dir = 1; step(); start = 0;
      en = 1;
      for (int k = 0; k < 5; k++) step();
      chk("t1 pre-reset cnt", int'(cnt), 5);
      rst_n = 0; start = 1; load = 1; load_val = 4'd7;
      step();
      chk_all("t1 first low edge", 0, 0, 0, 0);
      step(); step();
      chk_all("t1 held low", 0, 0, 0, 0);
      idle_in(); rst_n = 1;
      step();
      chk_all("t1 after release", 0, 0, 0, 0);

      // ---------------- test 2: wrap up-count, 25 steps ----------------
      do_reset();
      start = 1; dir = 1; mode = 0; step(); start = 0;
      chk_all("t2 start", 0, 0, 1, 0);
      en = 1; tc_cnt = 0;
      for (int k = 1; k <= 25; k++) begin
         step();
         chk($sformatf("t2 cnt step%0d", k), int'(cnt), k % 10);
         chk($sformatf("t2 tc step%0d", k), int'(tc), ((k % 10) == 9) ? 1 : 0);
         if (tc) tc_cnt++;
      end
      chk("t2 tc pulses", tc_cnt, 2);
      en = 0;

      // ---------------- test 3: one-shot down ----------------
      do_reset();
      start = 1; dir = 0; mode = 1; step(); start = 0;
      chk_all("t3 start", 9, 0, 1, 0);
      en = 1;
      for (int k = 1; k <= 9; k++) begin
         step();
         chk_all($sformatf("t3 step%0d", k), 9 - k, (k == 9) ? 1 : 0,
                 (k == 9) ? 0 : 1, (k == 9) ? 1 : 0);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         chk_all("t3 hold in done", 0, 0, 0, 1);
      end
      en = 0; start = 1; step(); start = 0;
      chk_all("t3 restart", 9, 0, 1, 0);

      // ---------------- table: load, dir flip, en gaps, simultaneous ----------------
      do_reset();
      //            en clr st ld lv dir md   cnt tc bsy dn
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0,  0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  2, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  3, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  4, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  3, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  2, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  9, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  9, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  8, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  8, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  7, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 1, 13, 0, 0, 9, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 9, 1, 0,  9, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0,  1, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, 3, 1, 0,  0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 5, 1, 0,  5, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  5, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 7, 1, 1,  7, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1,  8, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1,  9, 1, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1,  9, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 2, 1, 1,  2, 0, 0, 1));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1,  0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  9, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  9, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  8, 0, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         en = vecs[i].en; clr = vecs[i].clr; start = vecs[i].start;
         load = vecs[i].load; load_val = vecs[i].lv;
         dir = vecs[i].dir; mode = vecs[i].mode;
         step();
         chk_all($sformatf("vec%0d", i), int'(vecs[i].e_cnt), int'(vecs[i].e_tc),
                 int'(vecs[i].e_busy), int'(vecs[i].e_done));
      end
      idle_in();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of test, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule : tb_ex_cnt_mod
